data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port; the memory stage's load/store requests arrive on a valid/ready request channel.
- Performs byte/half/word stores with lane enables, and loads with sign or zero extension, after a parameterised access latency.
- Returns a response on a valid/ready response channel, so stalls upstream can be exercised.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_load_align.sv | 28 ++
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and lane-mask helper for the data-memory responder
package dmem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Byte lanes touched by an access of the given size at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the addressed lane(s) of a word and sign/zero extends them
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension to 32 bits
    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data     = 32'h0;
        case (size)
            SZ_BYTE: data = load_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = load_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with fixed access latency and valid/ready channels
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    import dmem_pkg::*;

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [1:0]         addr_lo_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req_bad;
    logic               done;
    logic [31:0]        rd_word;
    logic [31:0]        ld_data;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_lanes;

    // Legality check of the incoming request: size, alignment and word range
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            req_bad = 1'b1;
        end
    end

    // Completion edge of an access, plus store-lane replication of right-justified data
    always_comb begin
        done     = (state == ACCESS) && (cnt == '0);
        rd_word  = mem[idx_q];
        wr_mask  = lane_mask(size_q, addr_lo_q);
        wr_lanes = wdata_q;
        case (size_q)
            SZ_BYTE: wr_lanes = {4{wdata_q[7:0]}};
            SZ_HALF: wr_lanes = {2{wdata_q[15:0]}};
            default: wr_lanes = wdata_q;
        endcase
    end

    dmem_load_align u_load_align (
        .word          (rd_word),
        .addr_lo       (addr_lo_q),
        .size          (size_q),
        .load_unsigned (uns_q),
        .data          (ld_data)
    );

    // Backing array write on the completion edge; reset on that same edge suppresses it
    always_ff @(posedge clk) begin
        if (rst_n && done && !err_q && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // Request/access/response sequencing with registered handshake outputs.
    // Failing requests take one cycle through ACCESS so their response arrives one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            addr_lo_q <= 2'b00;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_lo_q <= req_addr[1:0];
                        idx_q     <= req_addr[IDX_W+1:2];
                        wdata_q   <= req_wdata;
                        err_q     <= req_bad;
                        cnt       <= req_bad ? '0 : CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (err_q || we_q) ? 32'h0 : ld_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    bit [7:0] bytes_m [4*DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed reference memory: stores write n little-endian bytes, loads rebuild an integer
    function automatic void model_op(input bit we, input bit [1:0] sz, input bit uns,
                                     input bit [31:0] a, input bit [31:0] wd,
                                     output bit err, output bit [31:0] rd);
        int n;
        longint v;
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
              || ((a / 4) >= 32'(DEPTH));
        rd = 32'h0;
        if (err) return;
        n = 1 << sz;
        if (we) begin
            for (int i = 0; i < n; i++) bytes_m[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(bytes_m[a + i]) << (8 * i));
            if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            rd = 32'(v);
        end
    endfunction

    task automatic send(input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, input bit keep_valid);
        int g;
        g = 0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_valid = keep_valid;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_op(input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd,
                         output bit [31:0] rd, output bit err, output int lat);
        send(we, sz, uns, a, wd, 1'b0);
        wait_rsp(lat);
        rd = rsp_rdata;
        err = rsp_err;
        complete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_prefill();
        bit [31:0] rd, wd, erd; bit err, eerr; int lat;
        for (int w = 0; w < 32; w++) begin
            wd = $urandom;
            model_op(1'b1, 2'd2, 1'b0, 32'(4 * w), wd, eerr, erd);
            do_op(1'b1, 2'd2, 1'b0, 32'(4 * w), wd, rd, err, lat);
            tests++; if (err !== eerr || rd !== erd) begin fails++; $display("FAIL prefill w%0d got err=%b rd=%h want err=%b rd=%h", w, err, rd, eerr, erd); end
        end
    endtask

    task automatic test_word();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, eerr, erd);
        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat);
        tests++; if (err !== 1'b0 || rd !== 32'h0 || lat != LAT) begin fails++; $display("FAIL word_store got err=%b rd=%h lat=%0d want 0/0/%0d", err, rd, lat, LAT); end
        rsp_ready = 1'b1;
        model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, eerr, erd);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL word_load_latency got %0d want %0d", lat, LAT); end
        tests++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin fails++; $display("FAIL word_load got rd=%h err=%b want deadbeef/0", rd, err); end
    endtask

    task automatic test_byte_ext();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        model_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h80, eerr, erd);
        do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h80, rd, err, lat);
        model_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, eerr, erd);
        do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, err, lat);
        tests++; if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin fails++; $display("FAIL byte_signed got %h want ffffff80", rd); end
        do_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, err, lat);
        tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL byte_unsigned got %h want 00000080", rd); end
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat);
        tests++; if (rd !== 32'hDEAD80EF) begin fails++; $display("FAIL byte_merge got %h want dead80ef", rd); end
    endtask

    task automatic test_errors();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        do_op(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, rd, err, lat);
        tests++; if (err !== 1'b1 || rd !== 32'h0 || lat != 1) begin fails++; $display("FAIL half_misaligned got err=%b rd=%h lat=%0d want 1/0/1", err, rd, lat); end
        do_op(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, rd, err, lat);
        tests++; if (err !== 1'b1 || rd !== 32'h0 || lat != 1) begin fails++; $display("FAIL word_out_of_range got err=%b rd=%h lat=%0d want 1/0/1", err, rd, lat); end
        do_op(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, rd, err, lat);
        tests++; if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL illegal_size got err=%b rd=%h want 1/0", err, rd); end
        model_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, eerr, erd);
        do_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, err, lat);
        tests++; if (rd !== erd || err !== 1'b0) begin fails++; $display("FAIL word0_unchanged got %h want %h", rd, erd); end
    endtask

    task automatic test_stall_bubble();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, eerr, erd);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        wait_rsp(lat);
        rd = rsp_rdata; err = rsp_err;
        tests++; if (rd !== erd || err !== 1'b0 || lat != LAT) begin fails++; $display("FAIL stall_first got rd=%h err=%b lat=%0d want %h/0/%0d", rd, err, lat, erd, LAT); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== err || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold c%0d got v=%b rd=%h err=%b rr=%b want 1/%h/%b/0", c, rsp_valid, rsp_rdata, rsp_err, req_ready, rd, err);
            end
        end
        complete();
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bubble got v=%b rr=%b want 0/1", rsp_valid, req_ready); end
        req_valid = 1'b0;
    endtask

    task automatic test_half();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        model_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, eerr, erd);
        do_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, rd, err, lat);
        do_op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, err, lat);
        tests++; if (rd !== 32'h00001234 || err !== 1'b0) begin fails++; $display("FAIL half_pos got %h want 00001234", rd); end
        model_op(1'b1, 2'd1, 1'b0, 32'h20, 32'hF00D, eerr, erd);
        do_op(1'b1, 2'd1, 1'b0, 32'h20, 32'hF00D, rd, err, lat);
        do_op(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, rd, err, lat);
        tests++; if (rd !== 32'hFFFFF00D || err !== 1'b0) begin fails++; $display("FAIL half_neg got %h want fffff00d", rd); end
    endtask

    task automatic test_reset_in_access();
        bit [31:0] rd, erd; bit err, eerr; int lat;
        send(1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5_5A5A, 1'b0);
        for (int i = 0; i < LAT; i++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL reset_in_access got rr=%b v=%b rd=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst_n = 1'b1;
        model_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, eerr, erd);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, err, lat);
        tests++; if (rd !== erd || err !== 1'b0) begin fails++; $display("FAIL reset_no_write got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        bit [31:0] rd, erd, a, wd; bit err, eerr, we, uns; bit [1:0] sz; int lat, elat;
        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
            else a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            model_op(we, sz, uns, a, wd, eerr, erd);
            elat = eerr ? 1 : LAT;
            send(we, sz, uns, a, wd, 1'b0);
            wait_rsp(lat);
            rd = rsp_rdata; err = rsp_err;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tests++;
            if (err !== eerr || rd !== erd || lat != elat || rsp_rdata !== rd) begin
                fails++;
                $display("FAIL random t%0d we=%b sz=%0d a=%h got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d", t, we, sz, a, err, rd, lat, eerr, erd, elat);
            end
            complete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4 * DEPTH; i++) bytes_m[i] = 8'h0;
        test_reset();
        test_prefill();
        test_word();
        test_byte_ext();
        test_errors();
        test_stall_bubble();
        test_half();
        test_reset_in_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
